detect_lane_scheduler: RTL and testbench

- Sequencer for the 4-lane character-detect datapath.
- Accepts one packed vector of per-lane detect results ({index, match} per lane) under a valid/ready handshake.
- Serialises the matching lanes onto a single output stream, one lane per transfer, lowest lane first.
- Keeps a saturating count of emitted matches; sits between the parallel detect lanes and the downstream single-lane consumer.

---
 rtl/detect_lane_scheduler.sv | 142 ++++++++++++++
 tb/tb_detect_lane_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/detect_lane_scheduler.sv
// Serialises the matching lanes of a packed 4-lane detect vector onto one output stream, lowest lane first.
// Latency: word accepted at edge T gives its first result in cycle T+1, then one result per cycle while out_ready is high.
// Backpressure: out_ready low holds the current result stable. det_ready is high in IDLE, or in the cycle the last result transfers.
//
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   det_valid/ready/data  - detect vector input; each lane is {index, match} with match at the lane LSB
//   out_valid/ready       - result handshake toward the single-lane consumer
//   out_lane/index/last   - lane number, its latched index, and a final-match-of-word flag
//   busy                  - high while results of a word are being drained
//   clear_count           - clears match_count; takes priority over a simultaneous increment
//   match_count           - saturating count of completed output transfers
module detect_lane_scheduler #(
  parameter int NUM_LANES = 4,
  parameter int INDEX_W   = 4,
  localparam int LANE_W   = $clog2(NUM_LANES)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               det_valid,
  output logic                               det_ready,
  input  logic [NUM_LANES*(INDEX_W+1)-1:0]   det_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [LANE_W-1:0]                  out_lane,
  output logic [INDEX_W-1:0]                 out_index,
  output logic                               out_last,
  output logic                               busy,
  input  logic                               clear_count,
  output logic [15:0]                        match_count
);

  localparam int SLOT_W = INDEX_W + 1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_LANES-1:0]   pend_q, pend_d;
  logic [INDEX_W-1:0]     idx_q [NUM_LANES];
  logic [15:0]            cnt_q, cnt_d;

  // Unpacked view of the incoming word.
  logic [NUM_LANES-1:0]   in_match;
  logic [INDEX_W-1:0]     in_idx [NUM_LANES];

  logic [LANE_W-1:0]      lane_sel;
  logic [NUM_LANES-1:0]   lane_onehot;
  logic                   one_left;
  logic                   accept;
  logic                   xfer;

  always_comb begin
    for (int g = 0; g < NUM_LANES; g++) begin
      in_match[g] = det_data[g*SLOT_W];
      in_idx[g]   = det_data[g*SLOT_W+1 +: INDEX_W];
    end
  end

  // Lowest set pending bit; scanning downward lets the lowest index win.
  always_comb begin
    lane_sel    = '0;
    lane_onehot = '0;
    for (int g = NUM_LANES - 1; g >= 0; g--) begin
      if (pend_q[g]) begin
        lane_sel    = LANE_W'(g);
        lane_onehot = NUM_LANES'(1) << g;
      end
    end
  end

  // Exactly one pending bit: non-zero and clearing the lowest bit leaves nothing.
  assign one_left = (pend_q != '0) && ((pend_q & (pend_q - NUM_LANES'(1))) == '0);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_lane  = '0;
    out_index = '0;
    out_last  = 1'b0;
    det_ready = 1'b0;

    unique case (state_q)
      IDLE: begin
        det_ready = 1'b1;
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_lane  = lane_sel;
        out_index = idx_q[lane_sel];
        out_last  = one_left;
        // A new word may be taken only as the current word's last result leaves.
        det_ready = out_ready && one_left;
      end
      default: ;
    endcase

    accept = det_valid && det_ready;
    xfer   = out_valid && out_ready;

    if (xfer) begin
      pend_d = pend_q & ~lane_onehot;
      if (one_left) state_d = IDLE;
    end

    // Acceptance in DRAIN only happens on the final transfer, so the reload
    // never loses a pending lane.
    if (accept) begin
      pend_d  = in_match;
      state_d = (in_match != '0) ? DRAIN : IDLE;
    end

    if (clear_count)                    cnt_d = '0;
    else if (xfer && cnt_q != CNT_MAX)  cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      for (int g = 0; g < NUM_LANES; g++) idx_q[g] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        for (int g = 0; g < NUM_LANES; g++) idx_q[g] <= in_idx[g];
      end
    end
  end

  assign match_count = cnt_q;

endmodule

// File: tb/tb_detect_lane_scheduler.sv
module tb_detect_lane_scheduler;

  logic        clk;
  logic        rst;
  logic        det_valid;
  logic        det_ready;
  logic [19:0] det_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane;
  logic [3:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        clear_count;
  logic [15:0] match_count;

  detect_lane_scheduler #(.NUM_LANES(4), .INDEX_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .det_valid   (det_valid),
    .det_ready   (det_ready),
    .det_data    (det_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_lane    (out_lane),
    .out_index   (out_index),
    .out_last    (out_last),
    .busy        (busy),
    .clear_count (clear_count),
    .match_count (match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] lane;
    logic [3:0] idx;
    logic       last;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   sb_en  = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build a detect word: idxs = {lane3,lane2,lane1,lane0} nibbles, m = match bits.
  function automatic logic [19:0] mk(input logic [15:0] idxs, input logic [3:0] m);
    logic [19:0] r;
    r = '0;
    for (int g = 0; g < 4; g++) r[g*5 +: 5] = {idxs[g*4 +: 4], m[g]};
    return r;
  endfunction

  // Sample point: falling edge; every completed transfer is popped and compared.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready && sb_en) begin
      n_chk++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_output observed lane=%0d idx=%0h expected no output", out_lane, out_index);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_result", 32'({out_lane, out_index, out_last}), 32'(e));
      end
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] idxs, input logic [3:0] m, output int waits);
    det_valid = 1'b1;
    det_data  = mk(idxs, m);
    waits = 0;
    forever begin
      sample();
      if (det_ready) break;
      waits++;
      if (waits > 50) begin
        check("send_timeout_det_ready", 32'(det_ready), 32'd1);
        break;
      end
      edge_();
    end
    if (sb_en) begin
      for (int g = 0; g < 4; g++) begin
        if (m[g]) sb.push_back('{lane: 2'(g), idx: idxs[g*4 +: 4], last: ((m >> (g + 1)) == 4'd0)});
      end
    end
    edge_();
    det_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      sample();
      if (!busy) break;
      edge_();
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    logic       pat      [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_lane [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};

    rst = 1'b1; det_valid = 1'b0; det_data = '0; out_ready = 1'b0; clear_count = 1'b0;
    edge_(); edge_();
    rst = 1'b0;
    sample();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_det_ready", 32'(det_ready), 32'd1);
    check("rst_count", 32'(match_count), 32'd0);
    check("rst_out_fields", 32'({out_lane, out_index, out_last}), 32'd0);
    edge_();

    // Three matches on lanes 0,2,3.
    out_ready = 1'b1;
    send_word(16'hF903, 4'b1101, w);
    sample();
    check("t1_c1_out_valid", 32'(out_valid), 32'd1);
    check("t1_c1_det_ready", 32'(det_ready), 32'd0);
    edge_(); sample();
    check("t1_c2_det_ready", 32'(det_ready), 32'd0);
    edge_(); sample();
    check("t1_c3_det_ready", 32'(det_ready), 32'd1);
    check("t1_c3_out_last", 32'(out_last), 32'd1);
    edge_(); sample();
    check("t1_idle_out_valid", 32'(out_valid), 32'd0);
    check("t1_count", 32'(match_count), 32'd3);
    edge_();

    // All-zero match word is absorbed silently.
    send_word(16'h1234, 4'b0000, w);
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t2_out_valid", 32'(out_valid), 32'd0);
      check("t2_det_ready", 32'(det_ready), 32'd1);
      edge_();
    end
    sample();
    check("t2_count", 32'(match_count), 32'd3);
    edge_();

    // Back-to-back single-match words.
    send_word(16'h0050, 4'b0010, w);
    send_word(16'hA000, 4'b1000, w);
    check("t3_b2b_waits", 32'(w), 32'd0);
    sample();
    check("t3_second_valid", 32'(out_valid), 32'd1);
    check("t3_second_lane", 32'(out_lane), 32'd3);
    edge_();
    wait_idle();
    check("t3_count", 32'(match_count), 32'd5);
    edge_();

    // All four lanes with stalls.
    send_word(16'h8421, 4'b1111, w);
    for (int k = 0; k < 6; k++) begin
      out_ready = pat[k];
      sample();
      check("t4_lane", 32'(out_lane), 32'(exp_lane[k]));
      check("t4_index", 32'(out_index), 32'(4'd1 << exp_lane[k]));
      check("t4_last", 32'(out_last), 32'(exp_lane[k] == 2'd3));
      edge_();
    end
    out_ready = 1'b1;
    wait_idle();
    check("t4_count", 32'(match_count), 32'd9);
    edge_();

    // Reset with two lanes pending.
    out_ready = 1'b0;
    send_word(16'h0760, 4'b0110, w);
    sample();
    check("t5_draining", 32'(busy), 32'd1);
    edge_();
    rst = 1'b1;
    sb.delete();
    sample(); edge_();
    rst = 1'b0;
    sample();
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_det_ready", 32'(det_ready), 32'd1);
    check("t5_count", 32'(match_count), 32'd0);
    edge_();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t5_no_stale", 32'(out_valid), 32'd0);
      edge_();
    end

    // Saturation: 16383 four-match words plus one two-match word = 65534.
    sb_en = 1'b0;
    for (int i = 0; i < 16383; i++) send_word(16'h4321, 4'b1111, w);
    send_word(16'h0021, 4'b0011, w);
    wait_idle();
    check("t6_preload", 32'(match_count), 32'hFFFE);
    edge_();
    sb_en = 1'b1;
    send_word(16'h0CBA, 4'b0111, w);
    wait_idle();
    check("t6_saturated", 32'(match_count), 32'hFFFF);
    edge_();
    send_word(16'h0700, 4'b0100, w);
    clear_count = 1'b1;
    sample();
    check("t6_xfer_with_clear", 32'(out_valid && out_ready), 32'd1);
    edge_();
    clear_count = 1'b0;
    sample();
    check("t6_cleared", 32'(match_count), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
